// File: rtl/memory_bus_interface_pkg.sv
// Shared encodings for the external memory bus interface:
// FSM states and byte-enable codes.
package memory_bus_interface_pkg;

  typedef enum logic [1:0] {
    MBI_IDLE,
    MBI_ACCESS,
    MBI_WAIT,
    MBI_COMPLETE
  } mbi_state_e;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_HIGH = 2'b10;
  localparam logic [1:0] BE_LOW  = 2'b01;

endpackage

// File: rtl/byte_lane_steer.sv
// Byte-lane steering for a 16-bit memory: byte enables,
// write-data replication and read-lane extraction.
module byte_lane_steer
  import memory_bus_interface_pkg::*;
(
  input  logic        bytex,
  input  logic        high_bytex,
  input  logic [15:0] wdata,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  be,
  output logic [15:0] mem_wdata,
  output logic [15:0] rdata
);

  always_comb begin
    be        = BE_WORD;
    mem_wdata = wdata;
    rdata     = mem_rdata;
    if (bytex) begin
      be        = high_bytex ? BE_HIGH : BE_LOW;
      mem_wdata = {wdata[7:0], wdata[7:0]};
      rdata     = {8'h00, high_bytex ? mem_rdata[15:8]
                                     : mem_rdata[7:0]};
    end
  end

endmodule

// File: rtl/memory_bus_interface.sv
// Single-request external memory cycle engine with
// programmable wait states and a DONE handshake.
module memory_bus_interface
  import memory_bus_interface_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int CW          = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic        BYTEX,
  input  logic        HIGH_BYTEX,
  input  logic [15:0] WDATA_CORE,
  input  logic        RD_REQ,
  input  logic        WR_REQ,
  output logic [15:0] RDATA_CORE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [14:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  output logic        MEM_CE,
  output logic        MEM_OE,
  output logic        MEM_WE,
  output logic [1:0]  MEM_BE
);

  if (WAIT_STATES < 0 || WAIT_STATES >= (1 << CW)) begin : g_ws_chk
    $error("WAIT_STATES does not fit the wait counter");
  end

  mbi_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          op_we, op_we_n;
  logic          op_byte, op_high;
  logic          req, accept, err_n, strobe_n;
  logic          use_req, st_byte, st_high;
  logic [1:0]    st_be;
  logic [15:0]   st_wdata, st_rdata;

  assign req = RD_REQ | WR_REQ;

  // Steer from the live request when accepting, else from the
  // latched attributes (read extraction on the way to COMPLETE).
  always_comb begin
    use_req = (state == MBI_IDLE) || (state == MBI_COMPLETE);
    st_byte = use_req ? BYTEX : op_byte;
    st_high = use_req ? HIGH_BYTEX : op_high;
  end

  byte_lane_steer u_steer (
    .bytex      (st_byte),
    .high_bytex (st_high),
    .wdata      (WDATA_CORE),
    .mem_rdata  (MEM_RDATA),
    .be         (st_be),
    .mem_wdata  (st_wdata),
    .rdata      (st_rdata)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      MBI_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_n = MBI_ACCESS;
        end
      end
      MBI_ACCESS, MBI_WAIT: begin
        err_n = req;
        if (cnt == '0) begin
          state_n = MBI_COMPLETE;
        end else begin
          state_n = MBI_WAIT;
          cnt_n   = cnt - 1'b1;
        end
      end
      MBI_COMPLETE: begin
        if (req) begin
          accept  = 1'b1;
          state_n = MBI_ACCESS;
        end else begin
          state_n = MBI_IDLE;
        end
      end
    endcase
    if (accept) begin
      cnt_n = CW'(WAIT_STATES);
      err_n = (RD_REQ & WR_REQ) | (~BYTEX & ADDR[0]);
    end
    op_we_n  = accept ? WR_REQ : op_we;
    strobe_n = (state_n == MBI_ACCESS) || (state_n == MBI_WAIT);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= MBI_IDLE;
      cnt        <= '0;
      op_we      <= 1'b0;
      op_byte    <= 1'b0;
      op_high    <= 1'b0;
      RDATA_CORE <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      MEM_CE     <= 1'b0;
      MEM_OE     <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_BE     <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      op_we  <= op_we_n;
      BUSY   <= strobe_n;
      MEM_CE <= strobe_n;
      MEM_OE <= strobe_n & ~op_we_n;
      MEM_WE <= strobe_n & op_we_n;
      DONE   <= (state_n == MBI_COMPLETE);
      ERR    <= err_n;
      if (accept) begin
        op_byte   <= BYTEX;
        op_high   <= HIGH_BYTEX;
        MEM_ADDR  <= ADDR[15:1];
        MEM_BE    <= st_be;
        MEM_WDATA <= st_wdata;
      end
      if (state_n == MBI_COMPLETE && !op_we) begin
        RDATA_CORE <= st_rdata;
      end
    end
  end

endmodule

// File: doc/memory_bus_interface.md
Name: memory_bus_interface

Overview:
Downstream consumer of the CPU's selected address bus (ADDR, HIGH_BYTEX) and byte-mode flag (BYTEX). Turns single read/write requests from the core into timed external-memory cycles on a 16-bit-wide memory. Handles byte-lane steering, programmable wait states and a DONE handshake back to the core. Sits between the address-bus mux and the external RAM/ROM port.

Parameters:
WAIT_STATES, 1, extra access cycles inserted after the first access cycle (0..15)
CW, 4, width of the wait-state counter

Ports:
CLK  in  1  system clock
RESET  in  1  reset, asynchronous, active-high
ADDR  in  16  byte address from the address-bus mux
BYTEX  in  1  1 = byte access, 0 = word access
HIGH_BYTEX  in  1  byte access targets the high lane (ADDR[0]&BYTEX)
WDATA_CORE  in  16  write data from the core; byte writes use bits [7:0]
RD_REQ  in  1  read request, sampled on CLK
WR_REQ  in  1  write request, sampled on CLK
RDATA_CORE  out  16  registered read result
BUSY  out  1  transaction in progress
DONE  out  1  one-cycle completion pulse
ERR  out  1  one-cycle protocol-error pulse
MEM_ADDR  out  15  word address (ADDR[15:1])
MEM_WDATA  out  16  write data to memory
MEM_RDATA  in  16  read data from memory
MEM_CE  out  1  chip enable
MEM_OE  out  1  output enable (reads)
MEM_WE  out  1  write enable
MEM_BE  out  2  byte enables: [1] = high lane, [0] = low lane

Behaviour:
- Reset:
  - state IDLE.
  - RDATA_CORE, MEM_ADDR, MEM_WDATA = 0.
  - MEM_BE = 00.
  - MEM_CE, MEM_OE, MEM_WE, BUSY, DONE and ERR = 0.
- Reset asserted mid-transaction: all strobes drop immediately (asynchronously); no DONE is issued; the transaction is lost.
- All outputs are registered.
- States:
  - IDLE: no transaction.
  - ACCESS: first memory cycle.
  - WAIT: wait-state cycles.
  - COMPLETE: result cycle.
- IDLE:
  - On a clock edge with RD_REQ or WR_REQ high: latch ADDR[15:1], BYTEX, HIGH_BYTEX, WDATA_CORE and the operation; go to ACCESS.
  - RD_REQ and WR_REQ both high: the write is performed and ERR pulses for 1 cycle.
- ACCESS:
  - MEM_CE=1, BUSY=1.
  - Read: MEM_OE=1. Write: MEM_WE=1.
  - Load counter with WAIT_STATES.
  - Counter = 0: go to COMPLETE. Otherwise go to WAIT.
- WAIT:
  - Strobes held.
  - Counter decrements each cycle.
  - Leave for COMPLETE on the edge where the counter reaches 0.
- COMPLETE:
  - Strobes are 0.
  - DONE=1 for exactly 1 cycle; BUSY=0.
  - On a read, RDATA_CORE was captured from MEM_RDATA on the edge entering COMPLETE.
- Latency: request sampled at edge E0, DONE is high in the cycle after edge E0+1+WAIT_STATES. With WAIT_STATES=1, DONE is high in the 3rd cycle after the request.
- Back-to-back: a request present in COMPLETE is accepted (same latch rules as IDLE) and goes straight to ACCESS. Otherwise return to IDLE.
- Requests during ACCESS/WAIT are ignored, not queued, and raise ERR for 1 cycle.
- Byte-lane rules:
  - Word access: MEM_BE=11; MEM_WDATA=WDATA_CORE; RDATA_CORE=MEM_RDATA.
  - Word access with ADDR[0]=1: bit 0 is ignored (aligned down) and ERR pulses; the access still completes.
  - Byte write: MEM_BE = HIGH_BYTEX ? 10 : 01; MEM_WDATA={WDATA_CORE[7:0],WDATA_CORE[7:0]}.
  - Byte read: RDATA_CORE = {8'h00, HIGH_BYTEX ? MEM_RDATA[15:8] : MEM_RDATA[7:0]}.
- RDATA_CORE holds its value until the next read completes; writes do not alter it.
- Counter wrap: none. WAIT_STATES must be < 2^CW; this is checked at elaboration.

Decomposition:
- Shared constants file:
  - state encodings MBI_IDLE / MBI_ACCESS / MBI_WAIT / MBI_COMPLETE.
  - byte-enable codes BE_WORD=2'b11, BE_HIGH=2'b10, BE_LOW=2'b01.
- One natural combinational sub-module, byte_lane_steer: produces MEM_BE, write-data replication and read-lane extraction.
- FSM and wait counter stay in the top module.

Test Plan:
- Word read, WAIT_STATES=1: ADDR=16'h1234, RD_REQ one cycle, MEM_RDATA=16'hBEEF -> MEM_ADDR=15'h091A, MEM_OE=1 for 2 cycles, DONE in 3rd cycle, RDATA_CORE=16'hBEEF.
- Byte high read: ADDR=16'h0011, BYTEX=1, HIGH_BYTEX=1, MEM_RDATA=16'hA55A -> MEM_BE=10, RDATA_CORE=16'h00A5. With ADDR=16'h0010, HIGH_BYTEX=0 -> MEM_BE=01, RDATA_CORE=16'h005A.
- Byte low write: ADDR=16'h0020, BYTEX=1, WDATA_CORE=16'h3377 -> MEM_WE=1, MEM_BE=01, MEM_WDATA=16'h7777, DONE 1 cycle, RDATA_CORE unchanged.
- Simultaneous RD_REQ+WR_REQ, then RD_REQ during WAIT -> write performed, ERR pulses at acceptance and again for the ignored request; only one DONE.
- RESET pulsed during WAIT -> MEM_CE/MEM_WE fall without waiting for CLK, state IDLE, no DONE. A subsequent read completes normally.
- WAIT_STATES=0, back-to-back reads with RD_REQ held high -> DONE every 2nd cycle, MEM_CE toggling 1,0,1,0.
